scan_test_ctrl: RTL and testbench

Tester-side scan controller that drives the scan port of a scan-inserted block, such as `scan_alu`, through its SE, SI and SO pins. For each test it does four things:
- shifts a stimulus pattern into the scan chain,
- pulses one functional capture cycle,
- shifts the captured response back out over SO,
- compares the response against an expected vector and reports pass/fail plus a mismatch count.

It sits between a pattern source (bench or on-chip BIST sequencer) and the scan chain of the block under test.

---
 rtl/scan_test_ctrl.sv | 178 +++++++++++++++++
 tb/tb_scan_test_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl
// Tester-side scan controller: shifts a stimulus pattern into a scan chain,
// pulses one functional capture cycle, shifts the response back out over SO
// and compares it against an expected vector.
//
// Optional feature macro: SCAN_MASK_EN
//   defined   -> adds the mask port; masked bits are excluded from the compare
//   undefined -> no mask port, all CHAIN_LEN bits are compared
//
// State table
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   IDLE      | SE=0, SI=0, waiting for start; latches operands on accept
//   SHIFT_IN  | SE=1, SI walks the pattern MSB first, CHAIN_LEN cycles
//   CAPTURE   | SE=0 for one cycle so the chain loads its functional data
//   SHIFT_OUT | SE=1, SI=0, SO sampled into captured, CHAIN_LEN cycles
//   DONE      | done pulse, results valid, then back to IDLE

module scan_test_ctrl #(
  parameter int CHAIN_LEN = 4,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
`ifdef SCAN_MASK_EN
  input  logic [CHAIN_LEN-1:0] mask,
`endif
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     mismatch_cnt,
  output logic [CHAIN_LEN-1:0] captured
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  // Pattern is held pre-shifted so the next SI bit is always the MSB.
  logic [CHAIN_LEN-1:0]   pat_q;
  logic [CHAIN_LEN-1:0]   exp_q;
`ifdef SCAN_MASK_EN
  logic [CHAIN_LEN-1:0]   mask_q;
`endif

  logic [CHAIN_LEN-1:0]   capt_next;
  logic [CHAIN_LEN-1:0]   diff;
  logic [CNT_W-1:0]       mis_next;

  function automatic logic [CNT_W-1:0] popcount(input logic [CHAIN_LEN-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Result of the compare as it will stand once the final SO bit lands.
  always_comb begin
    capt_next = {captured[CHAIN_LEN-2:0], SO};
`ifdef SCAN_MASK_EN
    diff      = (capt_next ^ exp_q) & ~mask_q;
`else
    diff      = capt_next ^ exp_q;
`endif
    mis_next  = popcount(diff);
  end

  // Sequencer with all outputs registered so SE/SI only move on rising edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      pat_q        <= '0;
      exp_q        <= '0;
`ifdef SCAN_MASK_EN
      mask_q       <= '0;
`endif
      SE           <= 1'b0;
      SI           <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      captured     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          SE <= 1'b0;
          SI <= 1'b0;
          if (start) begin
            // First SI bit is presented straight from the port so it is on
            // the wire during the very first SHIFT_IN cycle.
            pat_q        <= {pattern[CHAIN_LEN-2:0], 1'b0};
            exp_q        <= expected;
`ifdef SCAN_MASK_EN
            mask_q       <= mask;
`endif
            bit_cnt      <= '0;
            captured     <= '0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            busy         <= 1'b1;
            SE           <= 1'b1;
            SI           <= pattern[CHAIN_LEN-1];
            state        <= SHIFT_IN;
          end
        end

        SHIFT_IN: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            SE      <= 1'b0;
            SI      <= 1'b0;
            state   <= CAPTURE;
          end else begin
            bit_cnt <= bit_cnt + ONE;
            SI      <= pat_q[CHAIN_LEN-1];
            pat_q   <= {pat_q[CHAIN_LEN-2:0], 1'b0};
          end
        end

        CAPTURE: begin
          SE    <= 1'b1;
          SI    <= 1'b0;
          state <= SHIFT_OUT;
        end

        SHIFT_OUT: begin
          captured <= capt_next;
          SI       <= 1'b0;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt      <= '0;
            SE           <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            pass         <= (mis_next == '0);
            mismatch_cnt <= mis_next;
            state        <= DONE;
          end else begin
            bit_cnt <= bit_cnt + ONE;
          end
        end

        DONE: begin
          SE    <= 1'b0;
          SI    <= 1'b0;
          state <= IDLE;
        end

        default: begin
          SE    <= 1'b0;
          SI    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl with a 4-flop scan chain model that captures
// func_data in functional mode.
module tb_scan_test_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] pattern;
  logic [N-1:0] expected;
`ifdef SCAN_MASK_EN
  logic [N-1:0] mask_in;
`endif
  logic         SE;
  logic         SI;
  logic         SO;
  logic         busy;
  logic         done;
  logic         pass;
  logic [2:0]   mismatch_cnt;
  logic [N-1:0] captured;

  logic [N-1:0] chain = '0;
  logic [N-1:0] func_data = 4'b1010;

  int checks = 0;
  int errors = 0;

  scan_test_ctrl #(.CHAIN_LEN(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pattern      (pattern),
    .expected     (expected),
`ifdef SCAN_MASK_EN
    .mask         (mask_in),
`endif
    .SE           (SE),
    .SI           (SI),
    .SO           (SO),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .mismatch_cnt (mismatch_cnt),
    .captured     (captured)
  );

  always #5 clk = ~clk;

  // scan chain model: shift when SE, otherwise load functional data
  always @(posedge clk) begin
    if (SE) chain <= {chain[N-2:0], SI};
    else    chain <= func_data;
  end
  assign SO = chain[N-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // model: effective mask is zero when the mask feature is compiled out
  function automatic logic [N-1:0] eff_mask(input logic [N-1:0] m);
`ifdef SCAN_MASK_EN
    return m;
`else
    return m & 4'b0000;
`endif
  endfunction

  // Runs one test assuming the DUT is IDLE at the next edge.
  task automatic do_test(input string nm, input logic [N-1:0] p, input logic [N-1:0] e,
                         input logic [N-1:0] m, input logic [N-1:0] f,
                         input logic ep, input logic [2:0] emis, input logic [N-1:0] ecapt);
    int  c;
    bit  seen;
    pattern   = p;
    expected  = e;
`ifdef SCAN_MASK_EN
    mask_in   = m;
`endif
    func_data = f;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= N; k++) begin
      chk({nm, "_se_in"}, SE, 1);
      chk({nm, "_si"}, SI, p[N-k]);
      chk({nm, "_busy"}, busy, 1);
      step();
    end
    chk({nm, "_chain_pre_capture"}, chain, p);
    chk({nm, "_se_capture"}, SE, 0);
    c = N + 1;
    seen = 0;
    while (c < 40 && !seen) begin
      if (done) seen = 1;
      else begin
        step();
        c++;
      end
    end
    chk({nm, "_done_seen"}, seen, 1);
    chk({nm, "_done_cycle"}, c, 2*N + 2);
    chk({nm, "_pass"}, pass, ep);
    chk({nm, "_mis"}, mismatch_cnt, emis);
    chk({nm, "_capt"}, captured, ecapt);
    chk({nm, "_busy_done"}, busy, 0);
    step();
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_pass_hold"}, pass, ep);
    chk({nm, "_capt_hold"}, captured, ecapt);
    step();
  endtask

  typedef struct {
    logic [N-1:0] p;
    logic [N-1:0] e;
    logic [N-1:0] m;
    logic [N-1:0] f;
    logic         ep;
    logic [2:0]   emis;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [N-1:0] rp, re, rm, rf;
    int           rmis;
    int           done_q[$];
    int           c;
    bit           seen;

    tbl[0] = '{4'b1101, 4'b1010, 4'b0000, 4'b1010, 1'b1, 3'd0};
    tbl[1] = '{4'b0000, 4'b0110, 4'b0000, 4'b1010, 1'b0, 3'd2};
`ifdef SCAN_MASK_EN
    tbl[2] = '{4'b1111, 4'b0110, 4'b1100, 4'b1010, 1'b1, 3'd0};
    tbl[5] = '{4'b0110, 4'b1111, 4'b1000, 4'b0000, 1'b0, 3'd3};
`else
    tbl[2] = '{4'b1111, 4'b0110, 4'b1100, 4'b1010, 1'b0, 3'd2};
    tbl[5] = '{4'b0110, 4'b1111, 4'b1000, 4'b0000, 1'b0, 3'd4};
`endif
    tbl[3] = '{4'b0101, 4'b0101, 4'b0000, 4'b1010, 1'b0, 3'd4};
    tbl[4] = '{4'b1001, 4'b0011, 4'b0001, 4'b0011, 1'b1, 3'd0};

    rst_n    = 1'b0;
    start    = 1'b0;
    pattern  = '0;
    expected = '0;
`ifdef SCAN_MASK_EN
    mask_in  = '0;
`endif
    #2;
    chk("rst_se", SE, 0);
    chk("rst_si", SI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mis", mismatch_cnt, 0);
    chk("rst_capt", captured, 0);
    #10 rst_n = 1'b1;
    step();
    step();

    for (int i = 0; i < 6; i++) begin
      do_test($sformatf("tbl%0d", i), tbl[i].p, tbl[i].e, tbl[i].m, tbl[i].f,
              tbl[i].ep, tbl[i].emis, tbl[i].f);
    end

    for (int i = 0; i < 20; i++) begin
      rp   = 4'($urandom);
      re   = 4'($urandom);
      rm   = 4'($urandom);
      rf   = 4'($urandom);
      rmis = $countones((rf ^ re) & ~eff_mask(rm));
      do_test($sformatf("rnd%0d", i), rp, re, rm, rf, rmis == 0, 3'(rmis), rf);
    end

    // reset during the second SHIFT_OUT cycle
    pattern   = 4'b1101;
    expected  = 4'b1010;
    func_data = 4'b1010;
    start     = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    chk("mid_se_before", SE, 1);
    chk("mid_capt_partial", captured, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("mid_se", SE, 0);
    chk("mid_busy", busy, 0);
    chk("mid_pass", pass, 0);
    chk("mid_capt", captured, 0);
    chk("mid_done", done, 0);
    #3 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (done) seen = 1;
    end
    chk("mid_no_done", seen, 0);
    do_test("after_rst", 4'b0011, 4'b1010, 4'b0000, 4'b1010, 1'b1, 3'd0, 4'b1010);

    // start held high: one done per 11 cycles, results held in IDLE
    pattern   = 4'b1101;
    expected  = 4'b1010;
    func_data = 4'b1010;
    start     = 1'b1;
    step();
    for (c = 1; c <= 33; c++) begin
      if (done) begin
        done_q.push_back(c);
        chk($sformatf("hold_pass_c%0d", c), pass, 1);
      end
      if (c == 11) begin
        chk("hold_idle_pass", pass, 1);
        chk("hold_idle_capt", captured, 4'b1010);
        chk("hold_idle_busy", busy, 0);
      end
      step();
    end
    start = 1'b0;
    chk("hold_done_count", done_q.size(), 3);
    if (done_q.size() == 3) begin
      chk("hold_done0", done_q[0], 10);
      chk("hold_done1", done_q[1], 21);
      chk("hold_done2", done_q[2], 32);
    end
    seen = 0;
    for (int k = 0; k < 15 && !seen; k++) begin
      if (done) seen = 1;
      else step();
    end
    chk("hold_last_done", seen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
